// File: rtl/wb_regfile.sv
// Writeback consumer: decodes the destination of the retiring instruction, writes
// the 8x16 register file, serves two bypassed asynchronous read ports and counts writes.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [15:0]       wb_instr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        raddr1,
  input  logic [2:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              wr_en,
  output logic [2:0]        wr_reg,
  output logic [CNT_W-1:0]  wr_count
);

  logic [DATA_W-1:0] regs [NREG];
  logic [4:0]        op;
  logic              dec_writes;
  logic [2:0]        dec_reg;
  logic              unused_instr_bits;

  assign op                = wb_instr[15:11];
  assign unused_instr_bits = ^wb_instr[1:0];

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    dec_writes = 1'b0;
    dec_reg    = 3'd0;
    casez (op)
      5'b11011, 5'b111??, 5'b11001: begin
        dec_writes = 1'b1;
        dec_reg    = wb_instr[4:2];
      end
      5'b010??, 5'b101??, 5'b10001: begin
        dec_writes = 1'b1;
        dec_reg    = wb_instr[7:5];
      end
      5'b11000, 5'b10010, 5'b10011: begin
        dec_writes = 1'b1;
        dec_reg    = wb_instr[10:8];
      end
      5'b00110, 5'b00111: begin
        dec_writes = 1'b1;
        dec_reg    = 3'd7;
      end
      default: begin
        dec_writes = 1'b0;
        dec_reg    = 3'd0;
      end
    endcase
  end

  // Gating with rst_n drops any write presented while reset is held.
  assign wr_en  = rst_n & wb_valid & dec_writes;
  assign wr_reg = wr_en ? dec_reg : 3'd0;

  // NOTE: the register array is reset because software may read any register
  // before writing it; state updates use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     wr_count <= '0;
    else if (wr_en) wr_count <= wr_count + 1'b1;
  end

  // Same-cycle bypass lets decode see the value being written this cycle.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rst_n) begin
      rdata1 = (wr_en && raddr1 == wr_reg) ? wb_data : regs[raddr1];
      rdata2 = (wr_en && raddr2 == wr_reg) ? wb_data : regs[raddr2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps plus random traffic against
// a reference array/counter model built from the decode table.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [15:0] wb_instr;
  logic [15:0] wb_data;
  logic [2:0]  raddr1, raddr2;
  logic [15:0] rdata1, rdata2;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic [15:0] wr_count;

  logic [15:0] ref_regs [8];
  logic [15:0] ref_count;
  int          n_cmp = 0;
  int          n_err = 0;

  wb_regfile #(.DATA_W(16), .NREG(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_instr(wb_instr),
    .wb_data(wb_data), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1),
    .rdata2(rdata2), .wr_en(wr_en), .wr_reg(wr_reg), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Destination decode from the opcode table, using opcode values as numbers.
  task automatic ref_decode(input logic v, input logic [15:0] ins,
                            output logic en, output logic [2:0] r);
    int op;
    op = int'(ins[15:11]);
    en = 1'b0;
    r  = 3'd0;
    if (op == 27 || op == 25 || op >= 28) begin
      en = 1'b1; r = ins[4:2];
    end else if ((op >= 8 && op <= 11) || (op >= 20 && op <= 23) || op == 17) begin
      en = 1'b1; r = ins[7:5];
    end else if (op == 24 || op == 18 || op == 19) begin
      en = 1'b1; r = ins[10:8];
    end else if (op == 6 || op == 7) begin
      en = 1'b1; r = 3'd7;
    end
    if (!v) begin
      en = 1'b0; r = 3'd0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
    ref_count = 16'h0000;
  endtask

  // One cycle: drive at negedge, check combinational outputs, then retire at posedge.
  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] d,
                      input logic [2:0] a1, input logic [2:0] a2, input string tag);
    logic       e_en;
    logic [2:0] e_reg;
    logic [15:0] e1, e2;
    @(negedge clk);
    wb_valid = v; wb_instr = ins; wb_data = d; raddr1 = a1; raddr2 = a2;
    #1;
    ref_decode(v, ins, e_en, e_reg);
    e1 = (e_en && a1 == e_reg) ? d : ref_regs[a1];
    e2 = (e_en && a2 == e_reg) ? d : ref_regs[a2];
    chk({tag, ".wr_en"},    32'(wr_en),    32'(e_en));
    chk({tag, ".wr_reg"},   32'(wr_reg),   32'(e_reg));
    chk({tag, ".rdata1"},   32'(rdata1),   32'(e1));
    chk({tag, ".rdata2"},   32'(rdata2),   32'(e2));
    chk({tag, ".wr_count"}, 32'(wr_count), 32'(ref_count));
    @(posedge clk);
    if (e_en) begin
      ref_regs[e_reg] = d;
      ref_count       = ref_count + 16'd1;
    end
  endtask

  // Assert reset mid-cycle with a write presented; the write must be dropped.
  task automatic pulse_reset(input logic [2:0] a, input string tag);
    @(negedge clk);
    wb_valid = 1'b1; wb_instr = 16'h40A0; wb_data = 16'hDEAD; raddr1 = a; raddr2 = a;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk({tag, ".rdata1"},   32'(rdata1),   32'h0);
    chk({tag, ".rdata2"},   32'(rdata2),   32'h0);
    chk({tag, ".wr_en"},    32'(wr_en),    32'h0);
    chk({tag, ".wr_reg"},   32'(wr_reg),   32'h0);
    chk({tag, ".wr_count"}, 32'(wr_count), 32'h0);
    @(posedge clk);
    @(negedge clk);
    wb_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b1; wb_instr = 16'h40A0; wb_data = 16'hFFFF;
    raddr1 = 3'd5; raddr2 = 3'd0;
    model_clear();
    #3;
    chk("por.rdata1",   32'(rdata1),   32'h0);
    chk("por.wr_en",    32'(wr_en),    32'h0);
    chk("por.wr_count", 32'(wr_count), 32'h0);
    @(negedge clk);
    wb_valid = 1'b0;
    rst_n    = 1'b1;

    // Reset after a write to R3
    step(1'b1, 16'h4060, 16'h1234, 3'd3, 3'd3, "w_r3");
    step(1'b0, 16'h0000, 16'h0000, 3'd3, 3'd0, "rd_r3");
    pulse_reset(3'd3, "rst1");
    step(1'b0, 16'h0000, 16'h0000, 3'd3, 3'd5, "post_rst");

    // Decode of the four destination forms
    step(1'b1, 16'hD8E0, 16'hA000, 3'd0, 3'd1, "add_r0");
    step(1'b1, 16'h40A0, 16'h5A5A, 3'd5, 3'd0, "addi_r5");
    step(1'b1, 16'hC200, 16'h00C2, 3'd2, 3'd5, "lbi_r2");
    step(1'b1, 16'h3000, 16'h0042, 3'd7, 3'd2, "jal_r7");
    step(1'b0, 16'h0000, 16'h0000, 3'd7, 3'd5, "rd_r7");
    chk("r7_after_jal", 32'(ref_regs[7]), 32'h0042);

    // No-write opcodes, including an X writeback word
    step(1'b1, 16'h8000, 16'hFFFF, 3'd0, 3'd7, "st");
    step(1'b1, 16'h6000, 16'hxxxx, 3'd0, 3'd2, "beqz");
    step(1'b1, 16'h2000, 16'h1111, 3'd5, 3'd7, "j");
    step(1'b1, 16'h0000, 16'h2222, 3'd0, 3'd0, "halt");
    step(1'b0, 16'h0000, 16'h0000, 3'd2, 3'd7, "nowr_chk");

    // Bypass on both ports
    step(1'b1, 16'h4080, 16'h1111, 3'd4, 3'd4, "w_r4_old");
    step(1'b0, 16'h4080, 16'hBEEF, 3'd4, 3'd4, "byp_off");
    step(1'b1, 16'h4080, 16'hBEEF, 3'd4, 3'd4, "byp_on");
    step(1'b0, 16'h0000, 16'h0000, 3'd4, 3'd4, "rd_r4");

    // Back-to-back writes to R1
    step(1'b1, 16'h4020, 16'h0001, 3'd1, 3'd2, "b2b_1");
    step(1'b1, 16'h4020, 16'h0002, 3'd1, 3'd1, "b2b_2");
    step(1'b0, 16'h0000, 16'h0000, 3'd1, 3'd1, "b2b_rd");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins, d;
      logic [2:0]  a1, a2;
      logic        v;
      ins = 16'($urandom);
      d   = 16'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      a1  = 3'($urandom);
      a2  = ($urandom_range(0, 1) != 0) ? a1 : 3'($urandom);
      step(v, ins, d, a1, a2, "rand");
    end

    // Counter wrap
    pulse_reset(3'd5, "rst2");
    @(negedge clk);
    wb_valid = 1'b1; wb_instr = 16'h40A0; wb_data = 16'h5555;
    repeat (65535) @(posedge clk);
    ref_count   = ref_count + 16'hFFFF;
    ref_regs[5] = 16'h5555;
    @(negedge clk);
    wb_valid = 1'b0;
    #1 chk("cnt_ffff", 32'(wr_count), 32'(ref_count));
    step(1'b1, 16'h40A0, 16'h6666, 3'd5, 3'd0, "wrap_w");
    step(1'b0, 16'h0000, 16'h0000, 3'd5, 3'd0, "wrap_rd");
    chk("cnt_zero", 32'(wr_count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
